// File: rtl/rr_tree_pkg.sv
// Shared helpers for the pipelined round-robin tree arbiter: configuration
// legality check and a width-agnostic rotate-and-pick-first search.
package rr_tree_pkg;

    localparam int RR_MAX_W   = 64;
    localparam int RR_SEL_W   = $clog2(RR_MAX_W);

    // Legal when requesters split evenly into at least two groups that fit the search width.
    function automatic bit cfg_ok(input int n_req, input int group);
        if (group < 1 || group > RR_MAX_W) return 1'b0;
        if (n_req % group != 0) return 1'b0;
        if (n_req / group < 2) return 1'b0;
        return n_req <= RR_MAX_W;
    endfunction

    // First set bit of vec[n-1:0] at or after start, wrapping mod n.
    // Returns n when no bit is set. Iterating from the far end lets the
    // nearest hit overwrite any farther one without a found flag.
    function automatic int rr_pick(input logic [RR_MAX_W-1:0] vec, input int n, input int start);
        int pick;
        int idx;
        pick = n;
        for (int k = RR_MAX_W - 1; k >= 0; k--) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n && vec[idx[RR_SEL_W-1:0]]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_tree_arb_pipe_group.sv
// Leaf stage of the tree arbiter: holds one candidate per group, revalidates
// it against the live request bits, and reloads it round-robin.
module rr_group_cand
    import rr_tree_pkg::*;
#(
    parameter int GROUP = 4,
    localparam int LW   = (GROUP > 1) ? $clog2(GROUP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [GROUP-1:0] req,
    input  logic             win,
    output logic             elig,
    output logic [LW-1:0]    cand_idx
);

    logic                cand_vld;
    logic [LW-1:0]       ptr;
    logic                cand_req;
    logic                ld;
    logic [LW-1:0]       next_ptr;
    logic [LW-1:0]       start;
    logic [RR_MAX_W-1:0] req_ext;
    int                  pick;
    logic                found;
    logic [LW-1:0]       pick_idx;

    // Candidate check, reload condition and round-robin search from the pointer.
    always_comb begin
        cand_req = req[cand_idx];
        elig     = cand_vld & cand_req;
        ld       = !cand_vld | win | !cand_req;
        next_ptr = (cand_idx == LW'(GROUP - 1)) ? '0 : cand_idx + LW'(1);
        start    = win ? next_ptr : ptr;
        req_ext  = '0;
        req_ext[GROUP-1:0] = req;
        pick     = rr_pick(req_ext, GROUP, int'(start));
        found    = (pick < GROUP);
        pick_idx = pick[LW-1:0];
    end

    // Candidate reloads when stale or consumed; pointer moves only on a win.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_vld <= 1'b0;
            cand_idx <= '0;
            ptr      <= '0;
        end else begin
            if (ld) begin
                cand_vld <= found;
                cand_idx <= found ? pick_idx : '0;
            end
            if (win) ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/rr_tree_arb_pipe.sv
// Two-level pipelined round-robin arbiter: per-group candidates feed a
// top-level round-robin over groups, with a registered one-hot grant.
module rr_tree_arb_pipe
    import rr_tree_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int GROUP    = 4,
    localparam int N_GROUP = N_REQ / GROUP,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam int LW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int GW = $clog2(N_GROUP);

    if (!cfg_ok(N_REQ, GROUP)) begin : g_bad_cfg
        $error("rr_tree_arb_pipe: N_REQ must be a multiple of GROUP with at least two groups");
    end

    logic [N_GROUP-1:0]  elig;
    logic [N_GROUP-1:0]  win;
    logic [LW-1:0]       cand_idx [N_GROUP];
    logic [GW-1:0]       top_ptr;
    logic [RR_MAX_W-1:0] elig_ext;
    int                  wpick;
    logic                any;
    logic [GW-1:0]       w;
    logic [GW-1:0]       top_next;
    logic [IDX_W-1:0]    gidx;
    logic [N_REQ-1:0]    gnt_nxt;

    for (genvar g = 0; g < N_GROUP; g++) begin : g_grp
        rr_group_cand #(.GROUP(GROUP)) u_grp (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (req[g*GROUP +: GROUP]),
            .win      (win[g]),
            .elig     (elig[g]),
            .cand_idx (cand_idx[g])
        );
    end

    // Top-level round-robin over eligible groups and grant encode.
    always_comb begin
        elig_ext = '0;
        elig_ext[N_GROUP-1:0] = elig;
        wpick    = rr_pick(elig_ext, N_GROUP, int'(top_ptr));
        any      = (wpick < N_GROUP);
        w        = wpick[GW-1:0];
        top_next = (w == GW'(N_GROUP - 1)) ? '0 : w + GW'(1);
        win      = '0;
        gnt_nxt  = '0;
        gidx     = '0;
        if (any) begin
            win[w]        = 1'b1;
            gidx          = IDX_W'(w) * IDX_W'(GROUP) + IDX_W'(cand_idx[w]);
            gnt_nxt[gidx] = 1'b1;
        end
    end

    // Output register and top pointer; pointer holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            top_ptr <= '0;
        end else begin
            gnt     <= gnt_nxt;
            gnt_idx <= gidx;
            gnt_vld <= any;
            if (any) top_ptr <= top_next;
        end
    end

endmodule

// File: tb/tb_rr_tree_arb_pipe.sv
// Scoreboard bench for rr_tree_arb_pipe: an 8-requester (2x4) and a
// 12-requester (3x4) instance driven in parallel, checked against a
// cycle-level behavioural model, plus directed grant-sequence tables.
module tb_rr_tree_arb_pipe;

    typedef struct packed {
        logic [15:0]      cv;
        logic [15:0][7:0] ci;
        logic [15:0][7:0] ptr;
        logic [7:0]       tp;
        logic [15:0]      gnt;
        logic [7:0]       idx;
        logic             vld;
    } mdl_t;

    typedef struct packed {
        logic        lg;
        logic [7:0]  g8;
        logic [2:0]  i8;
        logic        v8;
        logic [11:0] g12;
        logic [3:0]  i12;
        logic        v12;
    } exp_t;

    logic        clk;
    logic        rst_n = 1'b0;
    logic [7:0]  req8  = '0;
    logic [11:0] req12 = '0;
    logic [7:0]  gnt8;
    logic [2:0]  idx8;
    logic        vld8;
    logic [11:0] gnt12;
    logic [3:0]  idx12;
    logic        vld12;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic log_en   = 1'b0;
    exp_t sb_q[$];
    int   log8[$];
    int   log12[$];
    mdl_t m8  = '0;
    mdl_t m12 = '0;

    rr_tree_arb_pipe #(.N_REQ(8), .GROUP(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .gnt_idx(idx8), .gnt_vld(vld8)
    );

    rr_tree_arb_pipe #(.N_REQ(12), .GROUP(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .req(req12), .gnt(gnt12), .gnt_idx(idx12), .gnt_vld(vld12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock of the arbiter, stated as the round-robin rules: revalidate
    // candidates, pick the next eligible group after the last winner, refill
    // consumed or stale candidates starting just past the previous choice.
    function automatic mdl_t step(input mdl_t s, input logic [15:0] r, input logic rst,
                                  input int n_req, input int grp);
        mdl_t n;
        int ng, w, p, c;
        logic [15:0] el;
        logic win;
        n  = s;
        ng = n_req / grp;
        if (!rst) begin
            n = '0;
            return n;
        end
        el = '0;
        for (int g = 0; g < ng; g++) el[g] = s.cv[g] && r[g*grp + int'(s.ci[g])];
        w = -1;
        for (int k = 0; k < ng; k++) begin
            c = (int'(s.tp) + k) % ng;
            if (w < 0 && el[c]) w = c;
        end
        if (w >= 0) begin
            n.idx = 8'(w*grp + int'(s.ci[w]));
            n.gnt = 16'(1) << n.idx;
            n.vld = 1'b1;
            n.tp  = 8'((w + 1) % ng);
        end else begin
            n.gnt = '0;
            n.idx = '0;
            n.vld = 1'b0;
        end
        for (int g = 0; g < ng; g++) begin
            win = (g == w);
            if (!s.cv[g] || win || !r[g*grp + int'(s.ci[g])]) begin
                p = win ? (int'(s.ci[g]) + 1) % grp : int'(s.ptr[g]);
                n.cv[g] = 1'b0;
                n.ci[g] = '0;
                for (int k = 0; k < grp; k++) begin
                    c = (p + k) % grp;
                    if (!n.cv[g] && r[g*grp + c]) begin
                        n.cv[g] = 1'b1;
                        n.ci[g] = 8'(c);
                    end
                end
            end
            if (win) n.ptr[g] = 8'((int'(s.ci[g]) + 1) % grp);
        end
        return n;
    endfunction

    // Requesters hold until granted, then may drop; occasionally withdraw early.
    function automatic logic [15:0] gen_req(input logic [15:0] cur, input logic [15:0] granted,
                                            input int n, input int dens);
        logic [15:0] r;
        r = cur;
        for (int i = 0; i < n; i++) begin
            if (cur[i]) begin
                if (granted[i] && $urandom_range(1, 0) == 1) r[i] = 1'b0;
                else if ($urandom_range(31, 0) == 0) r[i] = 1'b0;
            end else if ($urandom_range(99, 0) < dens) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic r, input logic [7:0] a, input logic [11:0] b);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req8  = a;
        req12 = b;
        m8  = step(m8,  {8'h00, a}, r, 8, 4);
        m12 = step(m12, {4'h0,  b}, r, 12, 4);
        e.lg  = log_en;
        e.g8  = m8.gnt[7:0];
        e.i8  = m8.idx[2:0];
        e.v8  = m8.vld;
        e.g12 = m12.gnt[11:0];
        e.i12 = m12.idx[3:0];
        e.v12 = m12.vld;
        sb_q.push_back(e);
    endtask

    task automatic check_log(input string nm, input int got[$], input int want[$]);
        for (int i = 0; i < want.size(); i++) begin
            n_checks++;
            if (i >= got.size()) begin
                n_fail++;
                $display("FAIL %s[%0d]: no grant recorded, want %0d", nm, i, want[i]);
            end else if (got[i] != want[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got idx %0d, want %0d (-1 = no grant)", nm, i, got[i], want[i]);
            end
        end
    endtask

    // Monitor: pops the expected response for each edge and compares both DUTs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({gnt8, idx8, vld8} !== {e.g8, e.i8, e.v8}) begin
                    n_fail++;
                    $display("FAIL sb8 @%0t: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                             $time, gnt8, idx8, vld8, e.g8, e.i8, e.v8);
                end
                n_checks++;
                if ({gnt12, idx12, vld12} !== {e.g12, e.i12, e.v12}) begin
                    n_fail++;
                    $display("FAIL sb12 @%0t: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                             $time, gnt12, idx12, vld12, e.g12, e.i12, e.v12);
                end
                if (e.lg) begin
                    log8.push_back(vld8 ? int'(idx8) : -1);
                    log12.push_back(vld12 ? int'(idx12) : -1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dens;
        logic r;
        logic [15:0] a, b;

        // Reset with all requesting, then full load on both configurations.
        drive(1'b0, 8'hFF, 12'hFFF);
        drive(1'b0, 8'hFF, 12'hFFF);
        log8.delete(); log12.delete(); log_en = 1'b1;
        repeat (14) drive(1'b1, 8'hFF, 12'hFFF);
        log_en = 1'b0;
        drive(1'b0, 8'hFF, 12'hFFF);
        check_log("full8",  log8,  '{-1, 0, 4, 1, 5, 2, 6, 3, 7, 0, 4, 1, 5, 2});
        check_log("full12", log12, '{-1, 0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11, 0});

        // Reset pulsed in the middle of a full-load run.
        log8.delete(); log12.delete(); log_en = 1'b1;
        repeat (4) drive(1'b1, 8'hFF, 12'hFFF);
        drive(1'b0, 8'hFF, 12'hFFF);
        repeat (6) drive(1'b1, 8'hFF, 12'hFFF);
        log_en = 1'b0;
        drive(1'b0, 8'h00, 12'h000);
        check_log("rst8",  log8,  '{-1, 0, 4, 1, -1, -1, 0, 4, 1, 5, 2});
        check_log("rst12", log12, '{-1, 0, 4, 8, -1, -1, 0, 4, 8, 1, 5});

        // Asymmetric load: group 1 has a single requester.
        log8.delete(); log12.delete(); log_en = 1'b1;
        repeat (11) drive(1'b1, 8'h1F, 12'h000);
        log_en = 1'b0;
        drive(1'b0, 8'h00, 12'h000);
        check_log("asym8", log8, '{-1, 0, 4, 1, 4, 2, 4, 3, 4, 0, 4});

        // Single requester 5, dropped in the cycle its grant is visible.
        log8.delete(); log12.delete(); log_en = 1'b1;
        drive(1'b1, 8'h20, 12'h020);
        drive(1'b1, 8'h20, 12'h020);
        repeat (4) drive(1'b1, 8'h00, 12'h000);
        log_en = 1'b0;
        drive(1'b0, 8'h00, 12'h000);
        check_log("single8",  log8,  '{-1, 5, -1, -1, -1, -1});
        check_log("single12", log12, '{-1, 5, -1, -1, -1, -1});

        // Request withdrawn after one cycle is never granted.
        log8.delete(); log12.delete(); log_en = 1'b1;
        drive(1'b1, 8'h04, 12'h004);
        repeat (5) drive(1'b1, 8'h00, 12'h000);
        log_en = 1'b0;
        drive(1'b0, 8'h00, 12'h000);
        check_log("wdraw8",  log8,  '{-1, -1, -1, -1, -1, -1});
        check_log("wdraw12", log12, '{-1, -1, -1, -1, -1, -1});

        // Randomized traffic with occasional resets.
        dens = 30;
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) dens = $urandom_range(90, 5);
            r = ($urandom_range(79, 0) == 0) ? 1'b0 : 1'b1;
            a = gen_req({8'h00, req8}, m8.gnt, 8, dens);
            b = gen_req({4'h0, req12}, m12.gnt, 12, dens);
            drive(r, a[7:0], b[11:0]);
        end
        repeat (2) drive(1'b1, 8'h00, 12'h000);

        @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
